// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage defaults: datapath width, reset PC, bubble encoding.
// Also provides a saturating increment for the optional perf counters.
package fetch_stage_pkg;

   localparam int          DEF_XLEN      = 32;
   localparam int          REG_W         = 5;
   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// Flush/stall-aware pipeline register; flush loads the bubble value.
// Flush beats stall so a squashed instruction never lingers.
module if_id_reg #(
   parameter int             W      = 32,
   parameter logic [W-1:0]   BUBBLE = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         stall,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // bubble on reset/flush, hold on stall, else capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= BUBBLE;
      else if (flush)
         q <= BUBBLE;
      else if (!stall)
         q <= d;
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, next-PC select, IF/ID register.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int               XLEN      = DEF_XLEN,
   parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DEF_RESET_PC),
   parameter logic [31:0]      NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              StallF,
   input  logic              StallD,
   input  logic              FlushD,
   input  logic              PCSrcE,
   input  logic [XLEN-1:0]   PCTargetE,
   input  logic [31:0]       InstrF,
   output logic [XLEN-1:0]   PCF,
   output logic [31:0]       InstrD,
   output logic [XLEN-1:0]   PCD,
   output logic [XLEN-1:0]   PCPlus4D,
   output logic              ValidD,
   output logic [REG_W-1:0]  Rs1D,
   output logic [REG_W-1:0]  Rs2D
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]      StallCntF
   ,output logic [31:0]      FlushCntD
`endif
);

   localparam int W = 1 + 2 * XLEN + 32;
   localparam logic [W-1:0] BUBBLE =
      {1'b0, {XLEN{1'b0}}, {XLEN{1'b0}}, NOP_INSTR};

   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_next;
   logic [W-1:0]    if_id_d;
   logic [W-1:0]    if_id_q;

   assign pc_plus4 = PCF + XLEN'(4);

   // redirect beats stall so a resolved branch is never lost
   always_comb begin
      pc_next = pc_plus4;
      if (PCSrcE)
         pc_next = {PCTargetE[XLEN-1:2], 2'b00};
      else if (StallF)
         pc_next = PCF;
   end

   // program counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         PCF <= RESET_PC;
      else
         PCF <= pc_next;
   end

   assign if_id_d = {1'b1, pc_plus4, PCF, InstrF};

   if_id_reg #(
      .W      (W),
      .BUBBLE (BUBBLE)
   ) u_if_id (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (FlushD),
      .stall (StallD),
      .d     (if_id_d),
      .q     (if_id_q)
   );

   assign {ValidD, PCPlus4D, PCD, InstrD} = if_id_q;
   assign Rs1D = InstrD[19:15];
   assign Rs2D = InstrD[24:20];

`ifdef FETCH_PERF_CNT_EN
   // saturating counts of real fetch stalls and decode flushes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCntF <= '0;
         FlushCntD <= '0;
      end else begin
         if (StallF && !PCSrcE)
            StallCntF <= sat_inc(StallCntF);
         if (FlushD)
            FlushCntD <= sat_inc(FlushCntD);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a queue-free
// behavioural model of PC sequencing and the IF/ID bundle.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] InstrF, InstrF_w;
   logic [31:0] PCF, InstrD, PCD, PCPlus4D;
   logic        ValidD;
   logic [4:0]  Rs1D, Rs2D;
   logic [31:0] PCF_w, InstrD_w, PCD_w, PCPlus4D_w;
   logic        ValidD_w;
   logic [4:0]  Rs1D_w, Rs2D_w;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] StallCntF, FlushCntD, StallCntF_w, FlushCntD_w;
   logic [31:0] m_scnt, m_fcnt;
`endif

   int total = 0;
   int bad = 0;

   logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
   logic        m_valid;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   assign InstrF   = mem(PCF);
   assign InstrF_w = mem(PCF_w);

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
      .PCPlus4D(PCPlus4D), .ValidD(ValidD), .Rs1D(Rs1D), .Rs2D(Rs2D)
`ifdef FETCH_PERF_CNT_EN
      , .StallCntF(StallCntF), .FlushCntD(FlushCntD)
`endif
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .InstrF(InstrF_w), .PCF(PCF_w), .InstrD(InstrD_w), .PCD(PCD_w),
      .PCPlus4D(PCPlus4D_w), .ValidD(ValidD_w), .Rs1D(Rs1D_w),
      .Rs2D(Rs2D_w)
`ifdef FETCH_PERF_CNT_EN
      , .StallCntF(StallCntF_w), .FlushCntD(FlushCntD_w)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = 32'h0;
      m_instr = 32'h0000_0013;
      m_pcd   = 32'h0;
      m_pc4d  = 32'h0;
      m_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      m_scnt = 32'h0;
      m_fcnt = 32'h0;
`endif
   endtask

   // one clock of spec behaviour, applied from the inputs seen at the edge
   task automatic model_edge();
      logic [31:0] seq;
      seq = m_pc + 32'd4;
      if (FlushD) begin
         m_instr = 32'h0000_0013;
         m_pcd   = 32'h0;
         m_pc4d  = 32'h0;
         m_valid = 1'b0;
      end else if (!StallD) begin
         m_instr = mem(m_pc);
         m_pcd   = m_pc;
         m_pc4d  = seq;
         m_valid = 1'b1;
      end
      if (PCSrcE)
         m_pc = PCTargetE & 32'hFFFF_FFFC;
      else if (!StallF)
         m_pc = seq;
`ifdef FETCH_PERF_CNT_EN
      if (StallF && !PCSrcE && m_scnt != 32'hFFFF_FFFF)
         m_scnt = m_scnt + 32'd1;
      if (FlushD && m_fcnt != 32'hFFFF_FFFF)
         m_fcnt = m_fcnt + 32'd1;
`endif
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".pcf"},   64'(PCF),      64'(m_pc));
      check({tag, ".instr"}, 64'(InstrD),   64'(m_instr));
      check({tag, ".pcd"},   64'(PCD),      64'(m_pcd));
      check({tag, ".pc4d"},  64'(PCPlus4D), 64'(m_pc4d));
      check({tag, ".valid"}, 64'(ValidD),   64'(m_valid));
      check({tag, ".rs1"},   64'(Rs1D),     64'(m_instr[19:15]));
      check({tag, ".rs2"},   64'(Rs2D),     64'(m_instr[24:20]));
`ifdef FETCH_PERF_CNT_EN
      check({tag, ".scnt"},  64'(StallCntF), 64'(m_scnt));
      check({tag, ".fcnt"},  64'(FlushCntD), 64'(m_fcnt));
`endif
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic idle();
      StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
      PCTargetE = 32'h0;
   endtask

   initial begin
      logic [31:0] held;
      rst_n = 1'b0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("rst");
      check("rst.pcf_w", 64'(PCF_w), 64'h0000_0000_FFFF_FFFC);

      @(negedge clk);
      rst_n = 1'b1;
      step("first");
      check("first.pcf4", 64'(PCF), 64'h4);
      check("first.vd", 64'(ValidD), 64'h1);
      check("wrap.pcf", 64'(PCF_w), 64'h0);
      check("wrap.pcd", 64'(PCD_w), 64'h0000_0000_FFFF_FFFC);
      check("wrap.pc4d", 64'(PCPlus4D_w), 64'h0);
      step("seq");
      check("seq.pcf8", 64'(PCF), 64'h8);
      step("seq");
      step("seq");
      check("seq.pcf10", 64'(PCF), 64'h10);

      StallF = 1'b1; StallD = 1'b1;
      held = InstrD;
      step("lu");
      check("lu.hold_pc", 64'(PCF), 64'h10);
      check("lu.hold_in", 64'(InstrD), 64'(held));
      idle();
      step("lu_go");
      check("lu.resume", 64'(PCF), 64'h14);

      PCSrcE = 1'b1; PCTargetE = 32'h40; FlushD = 1'b1;
      step("br");
      check("br.pcf", 64'(PCF), 64'h40);
      check("br.nop", 64'(InstrD), 64'h13);
      check("br.vd", 64'(ValidD), 64'h0);
      idle();
      step("br2");
      check("br2.pcd", 64'(PCD), 64'h40);

      StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h83;
      step("rvs");
      check("rvs.pcf", 64'(PCF), 64'h80);
      idle();

      for (int i = 0; i < 400; i++) begin
         StallF = ($urandom_range(0, 3) == 0);
         StallD = ($urandom_range(0, 3) == 0);
         FlushD = ($urandom_range(0, 5) == 0);
         PCSrcE = ($urandom_range(0, 7) == 0);
         PCTargetE = $urandom;
         step("rnd");
      end

      StallF = 1'b1; StallD = 1'b1;
      step("pre_rst");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      step("post_rst");
      check("post_rst.pcf", 64'(PCF), 64'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
